// File: rtl/sram_wb_ctrl_pkg.sv
// rtl/sram_wb_ctrl_pkg.sv - shared types and constants for the Wishbone-to-SRAM bridge
//
// Purpose: FSM state encoding, half-select tag values and the PHY halfword width.
// Ports:   none (package).

package sram_wb_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_LO,
        ISSUE_HI,
        DRAIN,
        ACK
    } state_e;

    // Tag values double as bit 0 of the PHY halfword address.
    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    localparam int HALF_W = 16;

endpackage

// File: rtl/sram_rd_capture.sv
// rtl/sram_rd_capture.sv - read-data capture pipe and 32-bit read buffer
//
// Purpose: delays each read strobe's half tag by READ_LATENCY cycles, then merges
//          the PHY halfword into the read buffer, byte-masked by the latched sel.
// Ports:
//   I_clk, I_reset   clock, synchronous active-high reset
//   I_clear          clear the read buffer (new transfer accepted)
//   I_push, I_tag    a read strobe is on the PHY this cycle, and its half (LO/HI)
//   I_sel            byte lane enables of the current transfer
//   I_phy_data       PHY read data
//   O_rdata_next     read buffer value after this clock edge
//   O_busy           a capture is still pending beyond this edge

module sram_rd_capture
    import sram_wb_ctrl_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic              I_clk,
    input  logic              I_reset,
    input  logic              I_clear,
    input  logic              I_push,
    input  logic              I_tag,
    input  logic [3:0]        I_sel,
    input  logic [HALF_W-1:0] I_phy_data,
    output logic [31:0]       O_rdata_next,
    output logic              O_busy
);

    localparam logic [READ_LATENCY-1:0] LAST = READ_LATENCY'(1) << (READ_LATENCY - 1);

    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [READ_LATENCY-1:0] tag_q, tag_d;
    logic [31:0]             buf_q, buf_d;

    always_comb begin
        int base;
        vld_d = (vld_q << 1) | READ_LATENCY'(I_push);
        tag_d = (tag_q << 1) | READ_LATENCY'(I_tag);
        buf_d = buf_q;
        base  = (tag_q[READ_LATENCY-1] == HALF_HI) ? 2 : 0;
        if (I_clear) begin
            buf_d = '0;
        end else if (vld_q[READ_LATENCY-1]) begin
            for (int b = 0; b < 2; b++) begin
                if (I_sel[base + b]) begin
                    buf_d[(base + b) * 8 +: 8] = I_phy_data[b * 8 +: 8];
                end
            end
        end
    end

    // The last stage is consumed at this edge, so it no longer counts as pending.
    assign O_busy       = |(vld_q & ~LAST);
    assign O_rdata_next = buf_d;

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            vld_q <= '0;
            tag_q <= '0;
            buf_q <= '0;
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
            buf_q <= buf_d;
        end
    end

endmodule

// File: rtl/sram_wb_ctrl.sv
// rtl/sram_wb_ctrl.sv - Wishbone 32-bit slave driving a 16-bit SRAM PHY
//
// Purpose: splits each word/halfword/byte access into one or two PHY halfword
//          transactions, collects read data and acknowledges the bus.
// Optional: SRAM_WB_CTRL_PERFCNT_EN enables the read/write ack counters;
//           without it O_cnt_rd/O_cnt_wr are tied to 0.
// Ports:
//   I_clk, I_reset                      clock, synchronous active-high reset
//   I_wb_cyc/stb/we/sel/adr/dat         Wishbone request (adr is a word address)
//   O_wb_dat, O_wb_ack                  Wishbone response
//   O_phy_stb/write/ub/lb/addr/data     PHY request (addr is a halfword address)
//   I_phy_data                          PHY read data, READ_LATENCY after strobe
//   O_cnt_rd, O_cnt_wr                  acknowledged read/write counters

module sram_wb_ctrl
    import sram_wb_ctrl_pkg::*;
#(
    parameter int ADDRBITS     = 18,
    parameter int READ_LATENCY = 2
) (
    input  logic                I_clk,
    input  logic                I_reset,
    input  logic                I_wb_cyc,
    input  logic                I_wb_stb,
    input  logic                I_wb_we,
    input  logic [3:0]          I_wb_sel,
    input  logic [ADDRBITS-2:0] I_wb_adr,
    input  logic [31:0]         I_wb_dat,
    output logic [31:0]         O_wb_dat,
    output logic                O_wb_ack,
    output logic                O_phy_stb,
    output logic                O_phy_write,
    output logic                O_phy_ub,
    output logic                O_phy_lb,
    output logic [ADDRBITS-1:0] O_phy_addr,
    output logic [HALF_W-1:0]   O_phy_data,
    input  logic [HALF_W-1:0]   I_phy_data,
    output logic [31:0]         O_cnt_rd,
    output logic [31:0]         O_cnt_wr
);

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [3:0]          sel_q, sel_d;
    logic [ADDRBITS-2:0] adr_q, adr_d;
    logic [31:0]         dat_q, dat_d;
    logic                stb_q, stb_d, write_q, write_d, ub_q, ub_d, lb_q, lb_d;
    logic [ADDRBITS-1:0] paddr_q, paddr_d;
    logic [HALF_W-1:0]   pdata_q, pdata_d;
    logic                ack_q, ack_d;
    logic [31:0]         wbdat_q, wbdat_d;
    logic                accept, go_lo, go_hi;
    logic [31:0]         rdata_next;
    logic                cap_busy;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        stb_d   = 1'b0;
        write_d = 1'b0;
        ub_d    = 1'b0;
        lb_d    = 1'b0;
        paddr_d = '0;
        pdata_d = '0;
        ack_d   = 1'b0;
        wbdat_d = '0;
        accept  = 1'b0;
        go_lo   = 1'b0;
        go_hi   = 1'b0;

        case (state_q)
            IDLE: begin
                if (I_wb_cyc && I_wb_stb) begin
                    accept = 1'b1;
                    we_d   = I_wb_we;
                    sel_d  = I_wb_sel;
                    adr_d  = I_wb_adr;
                    dat_d  = I_wb_dat;
                    if (|I_wb_sel[1:0]) begin
                        go_lo = 1'b1;
                    end else if (|I_wb_sel[3:2]) begin
                        go_hi = 1'b1;
                    end else begin
                        state_d = ACK;
                        ack_d   = I_wb_cyc;
                    end
                end
            end
            ISSUE_LO: begin
                if (|sel_q[3:2]) begin
                    go_hi = 1'b1;
                end else if (we_q) begin
                    state_d = ACK;
                    ack_d   = I_wb_cyc;
                end else begin
                    state_d = DRAIN;
                end
            end
            ISSUE_HI: begin
                if (we_q) begin
                    state_d = ACK;
                    ack_d   = I_wb_cyc;
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave once the final capture lands at this edge; take the merged value with it.
                if (!cap_busy) begin
                    state_d = ACK;
                    ack_d   = I_wb_cyc;
                    wbdat_d = rdata_next;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so the PHY request is formed on the edge entering ISSUE_*.
        if (go_lo || go_hi) begin
            state_d = go_hi ? ISSUE_HI : ISSUE_LO;
            stb_d   = 1'b1;
            write_d = we_d;
            paddr_d = {adr_d, go_hi};
            lb_d    = go_hi ? sel_d[2] : sel_d[0];
            ub_d    = go_hi ? sel_d[3] : sel_d[1];
            pdata_d = go_hi ? dat_d[31:16] : dat_d[15:0];
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            stb_q   <= 1'b0;
            write_q <= 1'b0;
            ub_q    <= 1'b0;
            lb_q    <= 1'b0;
            paddr_q <= '0;
            pdata_q <= '0;
            ack_q   <= 1'b0;
            wbdat_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            stb_q   <= stb_d;
            write_q <= write_d;
            ub_q    <= ub_d;
            lb_q    <= lb_d;
            paddr_q <= paddr_d;
            pdata_q <= pdata_d;
            ack_q   <= ack_d;
            wbdat_q <= wbdat_d;
        end
    end

    sram_rd_capture #(
        .READ_LATENCY(READ_LATENCY)
    ) u_capture (
        .I_clk       (I_clk),
        .I_reset     (I_reset),
        .I_clear     (accept),
        .I_push      (stb_q && !write_q),
        .I_tag       (paddr_q[0]),
        .I_sel       (sel_q),
        .I_phy_data  (I_phy_data),
        .O_rdata_next(rdata_next),
        .O_busy      (cap_busy)
    );

    assign O_wb_dat    = wbdat_q;
    assign O_wb_ack    = ack_q;
    assign O_phy_stb   = stb_q;
    assign O_phy_write = write_q;
    assign O_phy_ub    = ub_q;
    assign O_phy_lb    = lb_q;
    assign O_phy_addr  = paddr_q;
    assign O_phy_data  = pdata_q;

`ifdef SRAM_WB_CTRL_PERFCNT_EN
    logic [31:0] cnt_rd_q, cnt_rd_d, cnt_wr_q, cnt_wr_d;

    always_comb begin
        cnt_rd_d = cnt_rd_q + {31'b0, ack_q && !we_q};
        cnt_wr_d = cnt_wr_q + {31'b0, ack_q && we_q};
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            cnt_rd_q <= '0;
            cnt_wr_q <= '0;
        end else begin
            cnt_rd_q <= cnt_rd_d;
            cnt_wr_q <= cnt_wr_d;
        end
    end

    assign O_cnt_rd = cnt_rd_q;
    assign O_cnt_wr = cnt_wr_q;
`else
    assign O_cnt_rd = '0;
    assign O_cnt_wr = '0;
`endif

endmodule
